// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer
//   Central controller for the CNN inference datapath. Walks the convolution raster scan,
//   then hands off to pooling, flattening and fully connected stages via start/done
//   handshakes, and pulses o_out_valid at the end. External weight writes are granted only
//   while no inference is in flight.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 inference request (sampled each cycle)
//   i_wr_req / o_wr_grant   external weight-write request / grant
//   o_tile_row, o_tile_col  current convolution tile; o_tile_valid = write outfmap now
//   o_pool_start/i_pool_done, o_flat_start/i_flat_done, o_fc_start/i_fc_done  stage handshakes
//   o_out_valid             one-cycle result-valid pulse
//   o_busy                  inference in flight (CONV through OUT)
//   o_error                 one-cycle pulse on stage timeout
module cnn_layer_sequencer #(
    parameter int CONV_WIDTH  = 10,
    parameter int CONV_HEIGHT = 10,
    parameter int TIMEOUT     = 16,
    parameter int ROW_W       = $clog2(CONV_HEIGHT),
    parameter int COL_W       = $clog2(CONV_WIDTH),
    parameter int TO_W        = $clog2(TIMEOUT + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_wr_req,
    output logic             o_wr_grant,
    output logic [ROW_W-1:0] o_tile_row,
    output logic [COL_W-1:0] o_tile_col,
    output logic             o_tile_valid,
    output logic             o_pool_start,
    input  logic             i_pool_done,
    output logic             o_flat_start,
    input  logic             i_flat_done,
    output logic             o_fc_start,
    input  logic             i_fc_done,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_error
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StConv,
        StPool,
        StFlat,
        StFc,
        StOut
    } state_e;

    state_e           r_state;
    logic             r_pending;
    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [TO_W-1:0]  r_cnt;
    logic             r_error;

    state_e           w_state_d;
    logic             w_pending_d;
    logic [ROW_W-1:0] w_row_d;
    logic [COL_W-1:0] w_col_d;
    logic [TO_W-1:0]  w_cnt_d;
    logic             w_error_d;

    logic             w_last_col;
    logic             w_last_row;
    logic             w_stage_done;
    state_e           w_stage_next;

    assign w_last_col = (r_col == COL_W'(CONV_WIDTH - 1));
    assign w_last_row = (r_row == ROW_W'(CONV_HEIGHT - 1));

    // Done input and successor for whichever handshake stage is active.
    always_comb begin
        w_stage_done = 1'b0;
        w_stage_next = StIdle;
        case (r_state)
            StPool: begin
                w_stage_done = i_pool_done;
                w_stage_next = StFlat;
            end
            StFlat: begin
                w_stage_done = i_flat_done;
                w_stage_next = StFc;
            end
            StFc: begin
                w_stage_done = i_fc_done;
                w_stage_next = StOut;
            end
            default: begin
                w_stage_done = 1'b0;
                w_stage_next = StIdle;
            end
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_pending_d = r_pending;
        w_row_d     = r_row;
        w_col_d     = r_col;
        w_cnt_d     = r_cnt;
        w_error_d   = 1'b0;

        unique case (r_state)
            StIdle: begin
                // A write request wins; a coincident start is remembered.
                if (i_wr_req) begin
                    w_state_d   = StLoad;
                    w_pending_d = i_start;
                end else if (i_start) begin
                    w_state_d = StConv;
                end
            end

            StLoad: begin
                if (!i_wr_req) begin
                    w_state_d   = (r_pending || i_start) ? StConv : StIdle;
                    w_pending_d = 1'b0;
                end else if (i_start) begin
                    w_pending_d = 1'b1;
                end
            end

            StConv: begin
                if (w_last_col) begin
                    w_col_d = '0;
                    if (w_last_row) begin
                        w_row_d   = '0;
                        w_state_d = StPool;
                        w_cnt_d   = '0;
                    end else begin
                        w_row_d = r_row + 1'b1;
                    end
                end else begin
                    w_col_d = r_col + 1'b1;
                end
            end

            StPool, StFlat, StFc: begin
                // r_cnt == 0 marks the start-pulse cycle, where done is not yet looked at.
                if (r_cnt != '0 && w_stage_done) begin
                    w_state_d = w_stage_next;
                    w_cnt_d   = '0;
                end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
                    w_state_d = StIdle;
                    w_error_d = 1'b1;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end

            StOut: begin
                w_state_d = StIdle;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_pending <= 1'b0;
            r_row     <= '0;
            r_col     <= '0;
            r_cnt     <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pending <= w_pending_d;
            r_row     <= w_row_d;
            r_col     <= w_col_d;
            r_cnt     <= w_cnt_d;
            r_error   <= w_error_d;
        end
    end

    assign o_wr_grant   = (r_state == StLoad);
    assign o_tile_valid = (r_state == StConv);
    assign o_tile_row   = r_row;
    assign o_tile_col   = r_col;
    assign o_pool_start = (r_state == StPool) && (r_cnt == '0);
    assign o_flat_start = (r_state == StFlat) && (r_cnt == '0);
    assign o_fc_start   = (r_state == StFc) && (r_cnt == '0);
    assign o_out_valid  = (r_state == StOut);
    assign o_busy       = (r_state == StConv) || (r_state == StPool) || (r_state == StFlat) ||
                          (r_state == StFc) || (r_state == StOut);
    assign o_error      = r_error;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
module tb_cnn_layer_sequencer;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       wr_req = 1'b0;
    logic       pool_done = 1'b0;
    logic       flat_done = 1'b0;
    logic       fc_done = 1'b0;
    logic       wr_grant, tile_valid, pool_start, flat_start, fc_start;
    logic       out_valid, busy, error;
    logic [3:0] tile_row, tile_col;

    cnn_layer_sequencer #(
        .CONV_WIDTH (W),
        .CONV_HEIGHT(H),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_wr_req    (wr_req),
        .o_wr_grant  (wr_grant),
        .o_tile_row  (tile_row),
        .o_tile_col  (tile_col),
        .o_tile_valid(tile_valid),
        .o_pool_start(pool_start),
        .i_pool_done (pool_done),
        .o_flat_start(flat_start),
        .i_flat_done (flat_done),
        .o_fc_start  (fc_start),
        .i_fc_done   (fc_done),
        .o_out_valid (out_valid),
        .o_busy      (busy),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    // Cycle k spans posedge k .. posedge k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds: 0 tile, 1 pool_start, 2 flat_start, 3 fc_start, 4 out_valid, 5 error.
    typedef struct {
        int c;
        int k;
        int r;
        int col;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    int n_tests = 0;
    int n_fail = 0;
    int grant_cycles = 0;

    // Stage responder modes: 0 = done one cycle after start, 1 = never, 2 = held high.
    int   pool_mode = 0, flat_mode = 0, fc_mode = 0;
    logic ps_seen = 1'b0, fs_seen = 1'b0, cs_seen = 1'b0;

    always @(posedge clk) begin
        #1;
        pool_done = (pool_mode == 2) || (pool_mode == 0 && ps_seen);
        flat_done = (flat_mode == 2) || (flat_mode == 0 && fs_seen);
        fc_done   = (fc_mode == 2) || (fc_mode == 0 && cs_seen);
    end

    // Monitor: every output event is matched against the scoreboard in order.
    always @(negedge clk) begin
        logic [5:0] f;
        ps_seen = pool_start;
        fs_seen = flat_start;
        cs_seen = fc_start;
        if (wr_grant) grant_cycles++;
        n_tests++;
        if (wr_grant && busy) begin
            n_fail++;
            $display("FAIL grant_busy_excl cyc=%0d got grant=1 busy=1, required not both", cyc);
        end
        f = {error, out_valid, fc_start, flat_start, pool_start, tile_valid};
        for (int k = 0; k < 6; k++) begin
            if (f[k]) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d got kind=%0d (%0d,%0d), required none",
                             cyc, k, tile_row, tile_col);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.c != cyc || mon_e.k != k ||
                        (k == 0 && (32'(tile_row) != mon_e.r || 32'(tile_col) != mon_e.col))) begin
                        n_fail++;
                        $display("FAIL event cyc=%0d got kind=%0d (%0d,%0d), required cyc=%0d kind=%0d (%0d,%0d)",
                                 cyc, k, tile_row, tile_col, mon_e.c, mon_e.k, mon_e.r, mon_e.col);
                    end
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input int t);
        goto(t);
        start = 1'b1;
        goto(t + 1);
        start = 1'b0;
    endtask

    // Expected events for a run whose start is sampled in cycle t.
    task automatic expect_run(input int t, input bit flat_timeout);
        for (int i = 0; i < W * H; i++) exp_q.push_back('{t + 1 + i, 0, i / W, i % W});
        exp_q.push_back('{t + W * H + 1, 1, 0, 0});
        exp_q.push_back('{t + W * H + 3, 2, 0, 0});
        if (flat_timeout) begin
            exp_q.push_back('{t + W * H + 3 + TO, 5, 0, 0});
        end else begin
            exp_q.push_back('{t + W * H + 5, 3, 0, 0});
            exp_q.push_back('{t + W * H + 7, 4, 0, 0});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        goto(3);
        rst = 1'b0;
        n_tests++;
        if ({wr_grant, tile_valid, pool_start, flat_start, fc_start, out_valid, busy, error}
            !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b, required 00000000",
                     {wr_grant, tile_valid, pool_start, flat_start, fc_start, out_valid, busy, error});
        end
        n_tests++;
        if (tile_row !== 4'd0 || tile_col !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_tile got (%0d,%0d), required (0,0)", tile_row, tile_col);
        end
        goto(5);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_nominal();
        int t;
        t = cyc + 2;
        expect_run(t, 1'b0);
        pulse_start(t);
        goto(t + 107);
        n_tests++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL nominal_out got out_valid=%b busy=%b, required 1 1", out_valid, busy);
        end
        goto(t + 108);
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_idle got busy=%b out_valid=%b, required 0 0", busy, out_valid);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL nominal_drain got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_coincident();
        int c, g0;
        c = cyc + 2;
        expect_run(c + 3, 1'b0);
        goto(c);
        g0 = grant_cycles;
        start = 1'b1;
        wr_req = 1'b1;
        goto(c + 1);
        start = 1'b0;
        goto(c + 3);
        wr_req = 1'b0;
        n_tests++;
        if (wr_grant !== 1'b1 || tile_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_load got grant=%b tile_valid=%b, required 1 0", wr_grant, tile_valid);
        end
        goto(c + 4);
        n_tests++;
        if (wr_grant !== 1'b0 || tile_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL coinc_conv got grant=%b tile_valid=%b, required 0 1", wr_grant, tile_valid);
        end
        goto(c + 3 + 108);
        n_tests++;
        if (grant_cycles - g0 != 3) begin
            n_fail++;
            $display("FAIL coinc_grant_len got %0d cycles, required 3", grant_cycles - g0);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL coinc_drain got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_wr_during_run();
        int t, g0;
        t = cyc + 2;
        expect_run(t, 1'b0);
        pulse_start(t);
        pulse_start(t + 20);
        goto(t + 50);
        wr_req = 1'b1;
        g0 = grant_cycles;
        pulse_start(t + 60);
        goto(t + 108);
        n_tests++;
        if (grant_cycles != g0 || wr_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_run_nogrant got %0d grant cycles, required 0", grant_cycles - g0);
        end
        goto(t + 109);
        n_tests++;
        if (wr_grant !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_run_load got grant=%b busy=%b, required 1 0", wr_grant, busy);
        end
        goto(t + 115);
        wr_req = 1'b0;
        goto(t + 117);
        n_tests++;
        if (wr_grant !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_run_after got grant=%b busy=%b, required 0 0", wr_grant, busy);
        end
        goto(t + 130);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_run_drain got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int t;
        flat_mode = 1;
        t = cyc + 2;
        expect_run(t, 1'b1);
        pulse_start(t);
        goto(t + 103 + TO);
        n_tests++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_err got error=%b busy=%b, required 1 0", error, busy);
        end
        goto(t + 104 + TO);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse got error=%b, required 0", error);
        end
        flat_mode = 0;
        goto(t + 110 + TO);
        test_nominal();
    endtask

    task automatic test_pool_held();
        int t;
        pool_mode = 2;
        t = cyc + 3;
        expect_run(t, 1'b0);
        pulse_start(t);
        goto(t + 102);
        n_tests++;
        if (flat_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pool_held_wait got flat_start=%b busy=%b, required 0 1", flat_start, busy);
        end
        goto(t + 103);
        n_tests++;
        if (flat_start !== 1'b1) begin
            n_fail++;
            $display("FAIL pool_held_flat got flat_start=%b, required 1", flat_start);
        end
        goto(t + 110);
        pool_mode = 0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pool_held_drain got %0d pending events, required 0", exp_q.size());
        end
    endtask

    task automatic test_rst_mid();
        int t, t2;
        t = cyc + 3;
        for (int i = 0; i < 48; i++) exp_q.push_back('{t + 1 + i, 0, i / W, i % W});
        pulse_start(t);
        goto(t + 48);
        n_tests++;
        if (tile_row !== 4'd4 || tile_col !== 4'd7) begin
            n_fail++;
            $display("FAIL rst_mid_tile got (%0d,%0d), required (4,7)", tile_row, tile_col);
        end
        rst = 1'b1;
        goto(t + 49);
        rst = 1'b0;
        n_tests++;
        if ({wr_grant, tile_valid, pool_start, flat_start, fc_start, out_valid, busy, error,
             tile_row, tile_col} !== 16'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs got busy=%b tile_valid=%b (%0d,%0d), required all 0",
                     busy, tile_valid, tile_row, tile_col);
        end
        t2 = t + 55;
        expect_run(t2, 1'b0);
        pulse_start(t2);
        goto(t2 + 108);
        n_tests++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_rerun got %0d pending events busy=%b, required 0 0",
                     exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_coincident();
        test_wr_during_run();
        test_timeout();
        test_pool_held();
        test_rst_mid();
        goto(cyc + 5);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain got %0d pending events, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion by cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cnn_layer_sequencer.md
Name: cnn_layer_sequencer

Overview:
- Central controller for the CNN inference datapath.
- Sequences the convolution raster scan (tile row/col, outfmap write strobe), then the pooling, flattening and fully connected stages through start/done handshakes, and pulses out_valid.
- Arbitrates the shared feature/FC weight memories: external weight writes are granted only when no inference is in flight.

Parameters:
CONV_WIDTH, 10, convolution output columns (tile positions per row)
CONV_HEIGHT, 10, convolution output rows
TIMEOUT, 16, max cycles to wait for a stage done after its start pulse
ROW_W, $clog2(CONV_HEIGHT), tile_row width (derived)
COL_W, $clog2(CONV_WIDTH), tile_col width (derived)
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  inference request, sampled each cycle
wr_req  in  1  external weight-write request, level
wr_grant  out  1  weight memories may be written this cycle
tile_row  out  ROW_W  current convolution tile row
tile_col  out  COL_W  current convolution tile column
tile_valid  out  1  write convolution_outfmap[tile_row][tile_col] this cycle
pool_start  out  1  one-cycle pulse
pool_done  in  1  pooling complete
flat_start  out  1  one-cycle pulse
flat_done  in  1  flattening complete
fc_start  out  1  one-cycle pulse
fc_done  in  1  fully connected complete
out_valid  out  1  one-cycle pulse; cnn output is valid
busy  out  1  inference in flight (CONV through OUT)
error  out  1  one-cycle pulse on stage timeout

Behaviour:
- Reset: all outputs 0; state IDLE; tile_row/col=0; pending=0; timeout counter=0. rst wins over every other input and aborts any in-flight operation: state is IDLE the cycle after rst is sampled, and no start/valid pulse follows.
- States: IDLE, LOAD, CONV, POOL, FLAT, FC, OUT. All outputs are registered or decoded from state only; none depends combinationally on inputs.
- IDLE:
  - wr_req=1 -> LOAD. If start=1 in the same cycle, set pending=1; write has priority.
  - Else start=1 -> CONV.
- LOAD:
  - wr_grant=1 for every cycle in LOAD.
  - Stay while wr_req=1.
  - wr_req=0 -> CONV if pending, else IDLE. pending clears on leaving LOAD.
  - start seen in LOAD also sets pending.
- CONV:
  - tile_valid=1 every cycle, raster order (0,0),(0,1)..(0,W-1),(1,0)..(H-1,W-1): exactly CONV_WIDTH*CONV_HEIGHT cycles.
  - col wraps to 0 and row increments when col=W-1.
  - After tile (H-1,W-1): next state POOL; row/col return to 0.
- POOL/FLAT/FC (identical handshake):
  - The x_start pulse is high in the first cycle of the state only.
  - x_done is ignored in that first cycle; it is sampled from the next cycle on.
  - x_done=1 -> next stage (POOL->FLAT->FC->OUT).
  - The timeout counter clears on state entry and increments each waiting cycle. If it reaches TIMEOUT without done: error=1 for one cycle, state -> IDLE, no out_valid.
  - Done signals arriving in any other state are ignored.
- OUT: out_valid=1 for one cycle, then IDLE.
- busy=1 in CONV, POOL, FLAT, FC, OUT.
- start while busy or in LOAD-without-pending is dropped, not queued (exception: start in LOAD sets pending).
- wr_req while busy: wr_grant stays 0; LOAD is entered only from IDLE.
- wr_grant and busy are never both 1.
- Latency, with each done returning 1 cycle after its start and start at cycle t:
  - CONV t+1..t+W*H
  - POOL entered t+W*H+1
  - FLAT +2, FC +4
  - out_valid at t+W*H+7; IDLE at t+W*H+8
  - Defaults: out_valid at t+107.

Test Plan:
- Nominal run, defaults: start at cycle 0, each done 1 cycle after its start -> tile_valid cycles 1..100 with (row,col) ending (9,9); pool_start@101, flat_start@103, fc_start@105, out_valid@107, busy low @108.
- Coincident start and wr_req in IDLE, wr_req held 3 cycles -> wr_grant high 3 cycles, tile_valid never high while wr_grant is high, CONV entered the cycle after wr_req drops.
- wr_req raised at cycle 50 of a run -> wr_grant stays 0 until after out_valid; LOAD entered from IDLE; start pulses during the run are dropped (exactly one out_valid).
- flat_done never asserted, TIMEOUT=16 -> error pulse exactly once, 16 cycles after flat_start; fc_start never seen; IDLE next; a new start gives a clean full run.
- pool_done held high continuously from before POOL entry -> done ignored in the pool_start cycle, FLAT entered 2 cycles after POOL entry.
- rst asserted at tile (4,7) -> next cycle all outputs 0 and IDLE; a subsequent start rescans from (0,0).
